// File: rtl/seven_seg_time_display.sv
// Eight-digit multiplexed seven-segment display driver with a millisecond tick divider.
// A free-running double-dabble converter feeds a display register that the scan logic walks.
module seven_seg_time_display #(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ        = 1_000,
    parameter int unsigned REFRESH_CYCLES = 100_000,
    parameter int unsigned VAL_W          = 39
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [VAL_W-1:0] count_in,
    input  logic [7:0]       dp_mask,
    output logic             ms_tick,
    output logic [7:0]       cathode,
    output logic [7:0]       anode
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned DIV_W = $clog2(DIV);
    localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);
    localparam int unsigned SH_W  = $clog2(VAL_W);

    typedef enum logic [1:0] {CV_CAPTURE, CV_SHIFT, CV_COMMIT} cv_state_e;

    cv_state_e        cv_state_q, cv_state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ms_tick_q, ms_tick_d;
    logic [REF_W-1:0] scan_q, scan_d;
    logic [2:0]       idx_q, idx_d;
    logic [VAL_W-1:0] bin_q, bin_d;
    logic [31:0]      bcd_q, bcd_d, bcd_adj;
    logic [SH_W-1:0]  shcnt_q, shcnt_d;
    logic [31:0]      disp_q, disp_d;
    logic [7:0]       anode_q, anode_d;
    logic [7:0]       cathode_q, cathode_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // State register for every flop in the block.
    always_ff @(posedge clock) begin
        if (reset) begin
            cv_state_q <= CV_CAPTURE;
            div_q      <= '0;
            ms_tick_q  <= 1'b0;
            scan_q     <= '0;
            idx_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            shcnt_q    <= '0;
            disp_q     <= '0;
            anode_q    <= 8'hFF;
            cathode_q  <= 8'hFF;
        end else begin
            cv_state_q <= cv_state_d;
            div_q      <= div_d;
            ms_tick_q  <= ms_tick_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            shcnt_q    <= shcnt_d;
            disp_q     <= disp_d;
            anode_q    <= anode_d;
            cathode_q  <= cathode_d;
        end
    end

    // Converter next-state.
    always_comb begin
        cv_state_d = cv_state_q;
        case (cv_state_q)
            CV_CAPTURE: cv_state_d = CV_SHIFT;
            CV_SHIFT:   if (shcnt_q == SH_W'(VAL_W - 1)) cv_state_d = CV_COMMIT;
            CV_COMMIT:  cv_state_d = CV_CAPTURE;
            default:    cv_state_d = CV_CAPTURE;
        endcase
    end

    // Add-3 correction; carries out of digit 7 drop, giving value mod 10^8.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Converter datapath.
    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        shcnt_d = shcnt_q;
        disp_d  = disp_q;
        case (cv_state_q)
            CV_CAPTURE: begin
                bin_d   = count_in;
                bcd_d   = '0;
                shcnt_d = '0;
            end
            CV_SHIFT: begin
                bcd_d   = {bcd_adj[30:0], bin_q[VAL_W-1]};
                bin_d   = {bin_q[VAL_W-2:0], 1'b0};
                shcnt_d = shcnt_q + SH_W'(1);
            end
            CV_COMMIT: disp_d = bcd_q;
            default: ;
        endcase
    end

    // Tick divider, digit scan and registered pin drive.
    always_comb begin
        div_d     = (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + DIV_W'(1);
        ms_tick_d = (div_q == DIV_W'(DIV - 1));
        scan_d    = scan_q + REF_W'(1);
        idx_d     = idx_q;
        if (scan_q == REF_W'(REFRESH_CYCLES - 1)) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end
        anode_d   = ~(8'b1 << idx_q);
        cathode_d = {~dp_mask[idx_q], seg7(disp_q[4*idx_q +: 4])};
    end

    assign ms_tick = ms_tick_q;
    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule

// File: tb/tb_seven_seg_time_display.sv
// Directed bench for seven_seg_time_display: table of display vectors plus
// hand-written sequences for reset, tick timing and mid-conversion changes.
module tb_seven_seg_time_display;

    localparam int unsigned VAL_W = 39;
    localparam int unsigned SETTLE = 2 * (VAL_W + 3);

    logic             clock = 1'b0;
    logic             reset;
    logic [VAL_W-1:0] count_in;
    logic [7:0]       dp_mask;
    logic             ms_tick;
    logic [7:0]       cathode;
    logic [7:0]       anode;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [VAL_W-1:0] value;
        logic [7:0]       dpm;
        int               exp_num;
    } vec_t;

    vec_t vecs[7];

    seven_seg_time_display #(
        .CLK_FREQ_HZ(100),
        .TICK_HZ(10),
        .REFRESH_CYCLES(4),
        .VAL_W(VAL_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .count_in(count_in),
        .dp_mask(dp_mask),
        .ms_tick(ms_tick),
        .cathode(cathode),
        .anode(anode)
    );

    always #5 clock = ~clock;

    // Cycles since reset release; scan digit and tick phase follow from it.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'h40;
            1: seg_of = 7'h79;
            2: seg_of = 7'h24;
            3: seg_of = 7'h30;
            4: seg_of = 7'h19;
            5: seg_of = 7'h12;
            6: seg_of = 7'h02;
            7: seg_of = 7'h78;
            8: seg_of = 7'h00;
            9: seg_of = 7'h10;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    function automatic int digit_of(input int num, input int pos);
        int v;
        v = num;
        for (int k = 0; k < pos; k++) v = v / 10;
        return v % 10;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // One scan cycle: anode, cathode and tick against the bench model.
    task automatic check_cycle(input string tag, input int exp_num, input logic [7:0] dpm);
        int          idx;
        logic [7:0]  exp_an;
        logic [7:0]  exp_ca;
        logic [7:0]  one;
        idx    = ((cyc - 1) / 4) % 8;
        one    = 8'b1;
        exp_an = ~(one << idx);
        exp_ca = {~dpm[idx], seg_of(digit_of(exp_num, idx))};
        cmp8({tag, "_anode"}, anode, exp_an);
        cmp8({tag, "_cathode"}, cathode, exp_ca);
        cmp8({tag, "_ms_tick"}, {7'b0, ms_tick}, {7'b0, (cyc % 10) == 0});
    endtask

    initial begin
        vecs[0] = '{value: VAL_W'(12345678),  dpm: 8'h00,        exp_num: 12345678};
        vecs[1] = '{value: VAL_W'(0),         dpm: 8'b0010_1000, exp_num: 0};
        vecs[2] = '{value: VAL_W'(100000042), dpm: 8'h00,        exp_num: 42};
        vecs[3] = '{value: {VAL_W{1'b1}},     dpm: 8'hFF,        exp_num: 55813887};
        vecs[4] = '{value: VAL_W'(99999999),  dpm: 8'h81,        exp_num: 99999999};
        vecs[5] = '{value: VAL_W'(100000000), dpm: 8'h00,        exp_num: 0};
        vecs[6] = '{value: VAL_W'(1024),      dpm: 8'h0F,        exp_num: 1024};

        // Reset state.
        reset = 1'b1;
        count_in = '0;
        dp_mask = 8'h00;
        tick(3);
        cmp8("reset_anode", anode, 8'hFF);
        cmp8("reset_cathode", cathode, 8'hFF);
        cmp8("reset_ms_tick", {7'b0, ms_tick}, 8'h00);

        // Tick period and initial scan of zeros.
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            check_cycle("startup", 0, 8'h00);
        end

        // Table-driven display values.
        for (int v = 0; v < 7; v++) begin
            count_in = vecs[v].value;
            dp_mask  = vecs[v].dpm;
            tick(SETTLE);
            for (int i = 0; i < 32; i++) begin
                tick(1);
                check_cycle($sformatf("vec%0d", v), vecs[v].exp_num, vecs[v].dpm);
            end
        end

        // Change mid-conversion: old value holds through first commit, new arrives later.
        reset = 1'b1;
        count_in = VAL_W'(12345678);
        dp_mask = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(5);
        count_in = VAL_W'(87654321);
        tick(39);
        for (int i = 0; i < 32; i++) begin
            tick(1);
            check_cycle("midchg_old", 12345678, 8'h00);
        end
        tick(13);
        for (int i = 0; i < 32; i++) begin
            tick(1);
            check_cycle("midchg_new", 87654321, 8'h00);
        end

        // Reset while digit 5 is lit.
        for (int i = 0; i < 32 && (((cyc - 1) / 4) % 8) != 5; i++) tick(1);
        cmp8("pre_reset_digit5", anode, 8'hDF);
        reset = 1'b1;
        tick(1);
        cmp8("midscan_reset_anode", anode, 8'hFF);
        cmp8("midscan_reset_cathode", cathode, 8'hFF);
        cmp8("midscan_reset_ms_tick", {7'b0, ms_tick}, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            check_cycle("post_reset", 0, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
